// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Inter-stage pipeline register with valid, stall, flush and a
//            saturating Tnew countdown. Define STAGE_STATS_EN to add
//            stall/bubble event counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned TNEW_W   = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter bit          DEC_TNEW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_ins,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_payload,
    input  logic [4:0]        in_a3,
    input  logic              in_we,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic              out_valid,
    output logic [31:0]       out_ins,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc8,
    output logic [DATA_W-1:0] out_payload,
    output logic [4:0]        out_a3,
    output logic              out_we,
    output logic [TNEW_W-1:0] out_tnew
`ifdef STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    logic [TNEW_W-1:0] w_tnew_adv;
    logic              w_we_adv;

    generate
        if (DEC_TNEW) begin : g_tnew_dec
            // Saturate at zero so a finished producer never reads as "far away".
            assign w_tnew_adv = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
        end else begin : g_tnew_pass
            assign w_tnew_adv = in_tnew;
        end
    endgenerate

    assign w_we_adv = in_we & in_valid & (in_a3 != 5'd0);
    assign out_pc8  = out_pc + 32'd8;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_ins     <= 32'd0;
            out_pc      <= RESET_PC;
            out_payload <= '0;
            out_a3      <= 5'd0;
            out_we      <= 1'b0;
            out_tnew    <= '0;
        end else if (flush) begin
            // Bubble keeps the upstream PC for later EPC use.
            out_valid   <= 1'b0;
            out_ins     <= 32'd0;
            out_pc      <= in_pc;
            out_payload <= '0;
            out_a3      <= 5'd0;
            out_we      <= 1'b0;
            out_tnew    <= '0;
        end else if (!stall) begin
            out_valid   <= in_valid;
            out_ins     <= in_valid ? in_ins : 32'd0;
            out_pc      <= in_pc;
            out_payload <= in_payload;
            out_a3      <= in_a3;
            out_we      <= w_we_adv;
            out_tnew    <= in_valid ? w_tnew_adv : '0;
        end
    end

`ifdef STAGE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (!flush && stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush || (!stall && !in_valid))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Table-driven bench for pipe_stage_reg; a second instance with DEC_TNEW=0
// checks Tnew passthrough on the same stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid, in_we;
    logic [31:0] in_ins, in_pc;
    logic [63:0] in_payload;
    logic [4:0]  in_a3;
    logic [1:0]  in_tnew;

    logic        out_valid, out_we, nd_valid, nd_we;
    logic [31:0] out_ins, out_pc, out_pc8, nd_ins, nd_pc, nd_pc8;
    logic [63:0] out_payload, nd_payload;
    logic [4:0]  out_a3, nd_a3;
    logic [1:0]  out_tnew, nd_tnew;
`ifdef STAGE_STATS_EN
    logic [31:0] stall_cnt, bubble_cnt, nd_stall_cnt, nd_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .TNEW_W(2), .RESET_PC(32'h0000_3000), .DEC_TNEW(1'b1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_payload(in_payload),
        .in_a3(in_a3), .in_we(in_we), .in_tnew(in_tnew),
        .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc), .out_pc8(out_pc8),
        .out_payload(out_payload), .out_a3(out_a3), .out_we(out_we), .out_tnew(out_tnew)
`ifdef STAGE_STATS_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    pipe_stage_reg #(.DATA_W(64), .TNEW_W(2), .RESET_PC(32'h0000_3000), .DEC_TNEW(1'b0)) dut_nd (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc), .in_payload(in_payload),
        .in_a3(in_a3), .in_we(in_we), .in_tnew(in_tnew),
        .out_valid(nd_valid), .out_ins(nd_ins), .out_pc(nd_pc), .out_pc8(nd_pc8),
        .out_payload(nd_payload), .out_a3(nd_a3), .out_we(nd_we), .out_tnew(nd_tnew)
`ifdef STAGE_STATS_EN
        , .stall_cnt(nd_stall_cnt), .bubble_cnt(nd_bubble_cnt)
`endif
    );

    typedef struct {
        logic        stall, flush, valid;
        logic [31:0] ins, pc;
        logic [63:0] payload;
        logic [4:0]  a3;
        logic        we;
        logic [1:0]  tnew;
        logic        e_valid;
        logic [31:0] e_ins, e_pc, e_pc8;
        logic [63:0] e_payload;
        logic [4:0]  e_a3;
        logic        e_we;
        logic [1:0]  e_tnew, e_tnew_nd;
        int          e_stalls, e_bubbles;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [63:0] pl, input logic [4:0] a3,
                         input logic we, input logic [1:0] tn);
        stall = s; flush = f; in_valid = v; in_ins = ins; in_pc = pc;
        in_payload = pl; in_a3 = a3; in_we = we; in_tnew = tn;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_ins"},   64'(out_ins),   64'd0);
        chk({tag, "_pc"},    64'(out_pc),    64'h3000);
        chk({tag, "_pc8"},   64'(out_pc8),   64'h3008);
        chk({tag, "_pay"},   out_payload,    64'd0);
        chk({tag, "_a3"},    64'(out_a3),    64'd0);
        chk({tag, "_we"},    64'(out_we),    64'd0);
        chk({tag, "_tnew"},  64'(out_tnew),  64'd0);
`ifdef STAGE_STATS_EN
        chk({tag, "_stalls"},  64'(stall_cnt),  64'd0);
        chk({tag, "_bubbles"}, 64'(bubble_cnt), 64'd0);
`endif
    endtask

    initial begin
        // stall flush valid ins pc payload a3 we tnew | e_valid e_ins e_pc e_pc8 e_payload e_a3 e_we e_tnew e_tnew_nd stalls bubbles
        vecs[0]  = '{0,0,1, 32'h0043_0821, 32'h3004, 64'h1111, 5'd1, 1, 2'd2,
                     1, 32'h0043_0821, 32'h3004, 32'h300C, 64'h1111, 5'd1, 1, 2'd1, 2'd2, 0, 0};
        vecs[1]  = '{0,0,1, 32'h8C22_0004, 32'h3008, 64'h2222, 5'd2, 1, 2'd0,
                     1, 32'h8C22_0004, 32'h3008, 32'h3010, 64'h2222, 5'd2, 1, 2'd0, 2'd0, 0, 0};
        vecs[2]  = '{0,0,1, 32'hAC22_0008, 32'h300C, 64'h2A2A, 5'd0, 1, 2'd3,
                     1, 32'hAC22_0008, 32'h300C, 32'h3014, 64'h2A2A, 5'd0, 0, 2'd2, 2'd3, 0, 0};
        vecs[3]  = '{0,0,1, 32'h1234_5678, 32'h3010, 64'h3333, 5'd7, 1, 2'd3,
                     1, 32'h1234_5678, 32'h3010, 32'h3018, 64'h3333, 5'd7, 1, 2'd2, 2'd3, 0, 0};
        vecs[4]  = '{1,0,0, 32'hFFFF_FFFF, 32'h4000, 64'hAAAA, 5'd9, 1, 2'd1,
                     1, 32'h1234_5678, 32'h3010, 32'h3018, 64'h3333, 5'd7, 1, 2'd2, 2'd3, 1, 0};
        vecs[5]  = '{1,0,1, 32'hEEEE_EEEE, 32'h4004, 64'hBBBB, 5'd10, 0, 2'd0,
                     1, 32'h1234_5678, 32'h3010, 32'h3018, 64'h3333, 5'd7, 1, 2'd2, 2'd3, 2, 0};
        vecs[6]  = '{1,0,0, 32'hDDDD_DDDD, 32'h4008, 64'hCCCC, 5'd11, 1, 2'd2,
                     1, 32'h1234_5678, 32'h3010, 32'h3018, 64'h3333, 5'd7, 1, 2'd2, 2'd3, 3, 0};
        vecs[7]  = '{1,1,1, 32'hDEAD_BEEF, 32'h3020, 64'h5555, 5'd5, 1, 2'd3,
                     0, 32'h0, 32'h3020, 32'h3028, 64'h0, 5'd0, 0, 2'd0, 2'd0, 3, 1};
        vecs[8]  = '{0,0,0, 32'h0C00_0000, 32'h3024, 64'h4444, 5'd5, 1, 2'd2,
                     0, 32'h0, 32'h3024, 32'h302C, 64'h4444, 5'd5, 0, 2'd0, 2'd0, 3, 2};
        vecs[9]  = '{0,1,1, 32'h0000_0001, 32'h3028, 64'h6666, 5'd3, 1, 2'd1,
                     0, 32'h0, 32'h3028, 32'h3030, 64'h0, 5'd0, 0, 2'd0, 2'd0, 3, 3};
        vecs[10] = '{0,0,1, 32'h0000_0001, 32'hFFFF_FFFC, 64'h7777, 5'd31, 0, 2'd1,
                     1, 32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0004, 64'h7777, 5'd31, 0, 2'd0, 2'd1, 3, 3};

        drive(0, 0, 0, 32'h0, 32'h0, 64'h0, 5'd0, 0, 2'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].ins, vecs[i].pc,
                  vecs[i].payload, vecs[i].a3, vecs[i].we, vecs[i].tnew);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d_ins", i),   64'(out_ins),   64'(vecs[i].e_ins));
            chk($sformatf("v%0d_pc", i),    64'(out_pc),    64'(vecs[i].e_pc));
            chk($sformatf("v%0d_pc8", i),   64'(out_pc8),   64'(vecs[i].e_pc8));
            chk($sformatf("v%0d_pay", i),   out_payload,    vecs[i].e_payload);
            chk($sformatf("v%0d_a3", i),    64'(out_a3),    64'(vecs[i].e_a3));
            chk($sformatf("v%0d_we", i),    64'(out_we),    64'(vecs[i].e_we));
            chk($sformatf("v%0d_tnew", i),  64'(out_tnew),  64'(vecs[i].e_tnew));
            chk($sformatf("v%0d_tnew_nd", i), 64'(nd_tnew), 64'(vecs[i].e_tnew_nd));
`ifdef STAGE_STATS_EN
            chk($sformatf("v%0d_stalls", i),  64'(stall_cnt),  64'(vecs[i].e_stalls));
            chk($sformatf("v%0d_bubbles", i), 64'(bubble_cnt), 64'(vecs[i].e_bubbles));
`endif
            @(negedge clk);
        end

        // Load valid data, hold it with stall, then reset while still stalled.
        drive(0, 0, 1, 32'h0128_2020, 32'h3040, 64'h9999, 5'd4, 1, 2'd2);
        @(posedge clk);
        #1;
        chk("mid_load_we", 64'(out_we), 64'd1);
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_hold_pc", 64'(out_pc), 64'h3040);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("rst_mid_stall");

        // Reset also beats a concurrent flush.
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; flush = 1'b1; in_pc = 32'h3050;
        @(posedge clk);
        #1;
        chk("rst_flush_pc", 64'(out_pc), 64'h3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
